// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// Provides the FSM state encoding and the counter-width function.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit count needed to hold 0..w-1.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational full subtractor: d = x - y - bin, bout = borrow out.
// Ports: x, y, bin in; d, bout out. Two half-subtractors plus an OR.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  assign d1   = x ^ y;
  assign b1   = ~x & y;
  assign d    = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, start/done handshake.
// Ports: clk, rst(async hi), start, a, b -> busy, done, diff, borrow.
// Build option SERSUB_SAT_EN: clamp diff to 0 on final borrow.
import serial_subtractor_pkg::*;

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic [CNT_W-1:0] cnt;
  logic             brw;
  logic             d;
  logic             bn;

  fs_cell u_fs (
    .x    (op_a[0]),
    .y    (op_b[0]),
    .bin  (brw),
    .d    (d),
    .bout (bn)
  );

  // Result bits enter at the MSB and migrate down.
  assign res_nxt = {d, res[WIDTH-1:1]};

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= SHIFT;
            op_a  <= a;
            op_b  <= b;
            res   <= '0;
            cnt   <= '0;
            brw   <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          op_a <= op_a >> 1;
          op_b <= op_b >> 1;
          res  <= res_nxt;
          brw  <= bn;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            borrow <= bn;
`ifdef SERSUB_SAT_EN
            diff   <= bn ? '0 : res_nxt;
`else
            diff   <= res_nxt;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random bench for serial_subtractor (WIDTH=8).
// Checks reset, latency, results, back-to-back and abort.
module tb_serial_subtractor;

  localparam int W = 8;

`ifdef SERSUB_SAT_EN
  localparam logic [W-1:0] D35 = 8'h00;
  localparam logic [W-1:0] D01 = 8'h00;
`else
  localparam logic [W-1:0] D35 = 8'hFE;
  localparam logic [W-1:0] D01 = 8'hFF;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // done must never be high two cycles running
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      tests++;
      assert (!prev_done) else begin
        fails++;
        $error("FAIL done_twice observed=1 expected=0");
      end
    end
    prev_done = done;
  end

  function automatic logic [W-1:0] ref_diff(
    input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    r = x - y;
`ifdef SERSUB_SAT_EN
    if (x < y) r = '0;
`endif
    return r;
  endfunction

  // Entered at a negedge; exits at the negedge where done is seen.
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic op(input logic [W-1:0] x,
                    input logic [W-1:0] y,
                    input logic [W-1:0] ed,
                    input logic eb,
                    input string tag);
    int n;
    int nb;
    start = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    wait_done(n, nb);
    chk({tag, ".lat"}, 32'(n), 32'(W));
    chk({tag, ".busy"}, 32'(nb), 32'(W));
    chk({tag, ".diff"}, 32'(diff), 32'(ed));
    chk({tag, ".brw"}, 32'(borrow), 32'(eb));
    @(negedge clk);
    chk({tag, ".idle"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    int n;
    int nb;
    int dc;
    logic [W-1:0] x;
    logic [W-1:0] y;

    #1;
    chk("rst0.busy", 32'(busy), 32'd0);
    chk("rst0.done", 32'(done), 32'd0);
    chk("rst0.diff", 32'(diff), 32'd0);
    chk("rst0.brw", 32'(borrow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op(8'd5, 8'd3, 8'h02, 1'b0, "t2");

    // async reset mid-idle, checked before next edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t1.diff", 32'(diff), 32'd0);
    chk("t1.busy", 32'({busy, done}), 32'd0);
    chk("t1.brw", 32'(borrow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op(8'd3, 8'd5, D35, 1'b1, "t3");
    op(8'hFF, 8'hFF, 8'h00, 1'b0, "t4a");
    op(8'h00, 8'h01, D01, 1'b1, "t4b");
    op(8'h80, 8'h00, 8'h80, 1'b0, "t4c");

    // back-to-back with start held high
    start = 1'b1;
    a = 8'd9;
    b = 8'd4;
    @(negedge clk);
    a = 8'd77;
    b = 8'd66;
    wait_done(n, nb);
    chk("t5.lat1", 32'(n), 32'(W));
    chk("t5.diff1", 32'(diff), 32'h05);
    a = 8'd20;
    b = 8'd1;
    @(negedge clk);
    start = 1'b0;
    a = 8'd0;
    b = 8'd0;
    wait_done(n, nb);
    chk("t5.gap", 32'(n + 1), 32'(W + 1));
    chk("t5.diff2", 32'(diff), 32'h13);
    chk("t5.brw2", 32'(borrow), 32'd0);
    @(negedge clk);

    // abort during the fourth SHIFT cycle
    start = 1'b1;
    a = 8'd100;
    b = 8'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6.busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6.busy", 32'({busy, done}), 32'd0);
    chk("t6.diff", 32'(diff), 32'd0);
    chk("t6.brw", 32'(borrow), 32'd0);
    dc = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("t6.nodone", 32'(done_cnt), 32'(dc));
    op(8'd100, 8'd1, 8'd99, 1'b0, "t6b");

    repeat (20) begin
      x = W'($urandom);
      y = W'($urandom);
      op(x, y, ref_diff(x, y), x < y, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
